led_scan_sched: RTL and testbench



---
 rtl/led_scan_sched_if.sv | 26 ++
 rtl/led_scan_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_led_scan_sched.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_scan_sched_if.sv
// Write-client handshake, frame SRAM port and prefetch output of led_scan_sched.
// master = the scheduler side, slave = the surrounding environment.
interface led_scan_sched_if;
   logic        wr_req;
   logic [8:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_gnt;
   logic        mem_cen;
   logic        mem_wen;
   logic [8:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        rd_valid;
   logic [3:0]  rd_idx;
   logic [15:0] rd_data;

   modport master (
      input  wr_req, wr_addr, wr_data, mem_rdata,
      output wr_gnt, mem_cen, mem_wen, mem_addr, mem_wdata, rd_valid, rd_idx, rd_data
   );

   modport slave (
      output wr_req, wr_addr, wr_data, mem_rdata,
      input  wr_gnt, mem_cen, mem_wen, mem_addr, mem_wdata, rd_valid, rd_idx, rd_data
   );
endinterface

// File: rtl/led_scan_sched.sv
// Scan-line scheduler and frame SRAM arbiter: PWM/slot/line counters, next-line prefetch, write client.
// Optional tear detection is compiled in when LEDDC_TEAR_DET_EN is defined; otherwise tear is tied 0.
module led_scan_sched (
   input  logic                    GCK,
   input  logic                    rst,
   input  logic                    Vsync,
   input  logic                    mode,
   led_scan_sched_if.master        bus,
   output logic                    line_rdy,
   output logic                    line_start,
   output logic [4:0]              line,
   output logic [10:0]             slot,
   output logic [4:0]              pwm_cnt,
   output logic                    tear
);

   typedef enum logic [1:0] {
      ST_PRIME,
      ST_RUN,
      ST_FETCH
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  idx_reg, idx_next;
   logic        rd_req;
   logic [8:0]  rd_addr;
   logic        wr_gnt;

   logic        line_rdy_reg, line_start_reg, line_mode_reg, pf_done_reg;
   logic [4:0]  line_reg, pwm_reg;
   logic [10:0] slot_reg;
   logic [10:0] last_slot;
   logic [4:0]  line_inc;
   logic        advance, pwm_wrap, slot_wrap, pf_start;

   logic        mem_cen_reg, mem_wen_reg;
   logic [8:0]  mem_addr_reg;
   logic [15:0] mem_wdata_reg;
   logic        p1_valid_reg, p2_valid_reg, rd_valid_reg;
   logic [3:0]  p1_idx_reg, p2_idx_reg, rd_idx_reg;
   logic [15:0] rd_data_reg;

   assign last_slot = line_mode_reg ? 11'd1023 : 11'd2047;
   assign advance   = Vsync && line_rdy_reg;
   assign pwm_wrap  = (pwm_reg == 5'd31);
   assign slot_wrap = pwm_wrap && (slot_reg == last_slot);
   assign line_inc  = line_reg + 5'd1;
   // pf_done_reg stops a second fetch while the counters sit on (last, 0) with Vsync low
   assign pf_start  = (state_reg == ST_RUN) && (slot_reg == last_slot) &&
                      (pwm_reg == 5'd0) && !pf_done_reg;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      rd_req     = 1'b0;
      rd_addr    = {line_inc, idx_reg};
      case (state_reg)
         ST_PRIME: begin
            rd_req   = 1'b1;
            rd_addr  = {5'd0, idx_reg};
            idx_next = idx_reg + 4'd1;
            if (idx_reg == 4'd15) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (pf_start) begin
               rd_req     = 1'b1;
               rd_addr    = {line_inc, 4'd0};
               idx_next   = 4'd1;
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            rd_req   = 1'b1;
            idx_next = idx_reg + 4'd1;
            if (idx_reg == 4'd15) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_RUN;
            idx_next   = 4'd0;
         end
      endcase
   end

   // Reads own the port whenever they have something to issue
   assign wr_gnt = bus.wr_req && !rd_req;

   always_ff @(posedge GCK or posedge rst) begin
      if (rst) begin
         state_reg <= ST_PRIME;
         idx_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_ff @(posedge GCK or posedge rst) begin
      if (rst) begin
         mem_cen_reg   <= 1'b1;
         mem_wen_reg   <= 1'b1;
         mem_addr_reg  <= 9'd0;
         mem_wdata_reg <= 16'd0;
      end else if (rd_req) begin
         mem_cen_reg  <= 1'b0;
         mem_wen_reg  <= 1'b1;
         mem_addr_reg <= rd_addr;
      end else if (wr_gnt) begin
         mem_cen_reg   <= 1'b0;
         mem_wen_reg   <= 1'b0;
         mem_addr_reg  <= bus.wr_addr;
         mem_wdata_reg <= bus.wr_data;
      end else begin
         mem_cen_reg <= 1'b1;
         mem_wen_reg <= 1'b1;
      end
   end

   // Two tracking stages cover the port register and the SRAM access cycle
   always_ff @(posedge GCK or posedge rst) begin
      if (rst) begin
         p1_valid_reg <= 1'b0;
         p1_idx_reg   <= 4'd0;
         p2_valid_reg <= 1'b0;
         p2_idx_reg   <= 4'd0;
         rd_valid_reg <= 1'b0;
         rd_idx_reg   <= 4'd0;
         rd_data_reg  <= 16'd0;
      end else begin
         p1_valid_reg <= rd_req;
         p1_idx_reg   <= rd_addr[3:0];
         p2_valid_reg <= p1_valid_reg;
         p2_idx_reg   <= p1_idx_reg;
         rd_valid_reg <= p2_valid_reg;
         if (p2_valid_reg) begin
            rd_idx_reg  <= p2_idx_reg;
            rd_data_reg <= bus.mem_rdata;
         end
      end
   end

   always_ff @(posedge GCK or posedge rst) begin
      if (rst) begin
         line_rdy_reg   <= 1'b0;
         line_start_reg <= 1'b0;
         line_mode_reg  <= 1'b0;
         line_reg       <= 5'd0;
         slot_reg       <= 11'd0;
         pwm_reg        <= 5'd0;
         pf_done_reg    <= 1'b0;
      end else begin
         line_start_reg <= 1'b0;
         if (rd_valid_reg && (rd_idx_reg == 4'd15)) begin
            line_rdy_reg <= 1'b1;
         end
         // Tracks mode throughout priming; the value at line_rdy rise is the one kept
         if (!line_rdy_reg) begin
            line_mode_reg <= mode;
         end
         if (advance) begin
            pwm_reg <= pwm_reg + 5'd1;
            if (slot_wrap) begin
               slot_reg       <= 11'd0;
               line_reg       <= line_inc;
               line_start_reg <= 1'b1;
               line_mode_reg  <= mode;
            end else if (pwm_wrap) begin
               slot_reg <= slot_reg + 11'd1;
            end
         end
         if (pf_start) begin
            pf_done_reg <= 1'b1;
         end else if (advance && slot_wrap) begin
            pf_done_reg <= 1'b0;
         end
      end
   end

`ifdef LEDDC_TEAR_DET_EN
   logic pf_busy_reg, tear_reg, tear_hit;

   // Prefetch counts as in flight from its first read until its last word is delivered
   assign tear_hit = wr_gnt && ((bus.wr_addr[8:4] == line_reg) ||
                                ((bus.wr_addr[8:4] == line_inc) && pf_busy_reg));

   always_ff @(posedge GCK or posedge rst) begin
      if (rst) begin
         pf_busy_reg <= 1'b0;
         tear_reg    <= 1'b0;
      end else begin
         if (pf_start) begin
            pf_busy_reg <= 1'b1;
         end else if (rd_valid_reg && (rd_idx_reg == 4'd15)) begin
            pf_busy_reg <= 1'b0;
         end
         if (tear_hit) begin
            tear_reg <= 1'b1;
         end else if (advance && slot_wrap && (line_inc == 5'd0)) begin
            tear_reg <= 1'b0;
         end
      end
   end

   assign tear = tear_reg;
`else
   assign tear = 1'b0;
`endif

   assign bus.wr_gnt    = wr_gnt;
   assign bus.mem_cen   = mem_cen_reg;
   assign bus.mem_wen   = mem_wen_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.rd_valid  = rd_valid_reg;
   assign bus.rd_idx    = rd_idx_reg;
   assign bus.rd_data   = rd_data_reg;
   assign line_rdy      = line_rdy_reg;
   assign line_start    = line_start_reg;
   assign line          = line_reg;
   assign slot          = slot_reg;
   assign pwm_cnt       = pwm_reg;

endmodule

// File: tb/tb_led_scan_sched.sv
// Randomised bench for led_scan_sched: a cycle-level reference model built from the timing rules
// (read queue, delivery delay line, arithmetic counters) is compared with the DUT every cycle.
module tb_led_scan_sched;
   logic        GCK = 1'b0;
   logic        rst = 1'b1;
   logic        Vsync = 1'b0;
   logic        mode = 1'b1;
   logic        line_rdy, line_start, tear;
   logic [4:0]  line, pwm_cnt;
   logic [10:0] slot;

   led_scan_sched_if bus();

   led_scan_sched dut (
      .GCK        (GCK),
      .rst        (rst),
      .Vsync      (Vsync),
      .mode       (mode),
      .bus        (bus.master),
      .line_rdy   (line_rdy),
      .line_start (line_start),
      .line       (line),
      .slot       (slot),
      .pwm_cnt    (pwm_cnt),
      .tear       (tear)
   );

   always #5 GCK = ~GCK;

   // Frame SRAM: one-cycle read latency, write on the edge that sees wen low
   logic [15:0] sram [512];
   logic        sram_load = 1'b1;

   function automatic logic [15:0] init_word(input int a);
      return 16'(a * 40503 + 12345) ^ 16'h5AA5;
   endfunction

   always @(posedge GCK) begin
      if (sram_load) begin
         for (int i = 0; i < 512; i++) sram[i] <= init_word(i);
      end else if (!bus.mem_cen) begin
         if (bus.mem_wen) bus.mem_rdata <= sram[bus.mem_addr];
         else             sram[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int          m_line, m_slot, m_pwm, fetched_line, pf_out, rd_now;
   bit          m_mode, m_rdy, m_start, m_tear;
   int          rdq[$];
   logic [15:0] ref_mem [512];
   bit          p_v [2];
   logic [3:0]  p_idx [2];
   logic [15:0] p_dat [2];
   bit          e_rdv, e_cen, e_wen, e_gnt;
   logic [3:0]  e_idx;
   logic [15:0] e_dat, e_wdata;
   logic [8:0]  e_addr;

   // Stimulus state
   int cyc = 0, vs_low = 0, n_ls = 0, n_gnt_dut = 0, n_gnt_ref = 0;
   bit force_wr = 0, tear_done = 0, gnt_seen = 0;

   task automatic model_reset();
      m_line = 0; m_slot = 0; m_pwm = 0; m_mode = 0; m_rdy = 0; m_start = 0; m_tear = 0;
      fetched_line = -1; pf_out = 0; rd_now = -1;
      rdq = {};
      for (int i = 0; i < 16; i++) rdq.push_back(i);
      for (int i = 0; i < 2; i++) begin p_v[i] = 0; p_idx[i] = 0; p_dat[i] = 0; end
      e_rdv = 0; e_idx = 0; e_dat = 0; e_cen = 1; e_wen = 1; e_addr = 0; e_wdata = 0; e_gnt = 0;
   endtask

   task automatic check_reset();
      chk("rst_line_rdy", line_rdy, 0);
      chk("rst_line_start", line_start, 0);
      chk("rst_line", line, 0);
      chk("rst_slot", slot, 0);
      chk("rst_pwm_cnt", pwm_cnt, 0);
      chk("rst_tear", tear, 0);
      chk("rst_wr_gnt", bus.wr_gnt, 0);
      chk("rst_mem_cen", bus.mem_cen, 1);
      chk("rst_mem_wen", bus.mem_wen, 1);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_idx", bus.rd_idx, 0);
      chk("rst_rd_data", bus.rd_data, 0);
   endtask

   task automatic compare();
      chk("line_rdy", line_rdy, m_rdy);
      chk("line_start", line_start, m_start);
      chk("line", line, m_line);
      chk("slot", slot, m_slot);
      chk("pwm_cnt", pwm_cnt, m_pwm);
      chk("mem_cen", bus.mem_cen, e_cen);
      chk("mem_wen", bus.mem_wen, e_wen);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
      chk("rd_valid", bus.rd_valid, e_rdv);
      if (e_rdv) begin
         chk("rd_idx", bus.rd_idx, e_idx);
         chk("rd_data", bus.rd_data, e_dat);
      end
`ifdef LEDDC_TEAR_DET_EN
      chk("tear", tear, m_tear);
`else
      chk("tear", tear, 0);
`endif
      if (line_start === 1'b1) n_ls++;
   endtask

   // One cycle of model + stimulus, called on the falling edge before the next rising edge
   task automatic step();
      int  last;
      bit  hit, rdy_n, wrap;
      last = m_mode ? 1023 : 2047;
      if (m_rdy && m_slot == last && m_pwm == 0 && fetched_line != m_line) begin
         fetched_line = m_line;
         pf_out   = 16;
         vs_low   = 10;
         force_wr = 1;
         for (int i = 0; i < 16; i++) rdq.push_back(((m_line + 1) % 32) * 16 + i);
      end
      rd_now = (rdq.size() > 0) ? rdq.pop_front() : -1;

      // Inputs for this cycle
      if (cyc < 40) Vsync = 1'b0;
      else if (vs_low > 0) begin Vsync = 1'b0; vs_low--; end
      else if ($urandom_range(0, 499) == 0) begin Vsync = 1'b0; vs_low = $urandom_range(0, 7); end
      else Vsync = 1'b1;
      mode = (m_line == 0) && (m_slot < 500);
      if (bus.wr_req && gnt_seen) bus.wr_req = 1'b0;
      if (!bus.wr_req) begin
         if (!tear_done && m_rdy && m_line == 0 && m_slot >= 200) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = 9'h003;
            bus.wr_data = 16'($urandom);
            tear_done   = 1;
         end else if (m_rdy && (force_wr || $urandom_range(0, 199) == 0)) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = {5'((m_line + 2 + $urandom_range(0, 29)) % 32), 4'($urandom)};
            bus.wr_data = 16'($urandom);
            force_wr    = 0;
         end
      end

      #1;
      e_gnt = bus.wr_req && (rd_now < 0);
      chk("wr_gnt", bus.wr_gnt, e_gnt);
      gnt_seen = (bus.wr_gnt === 1'b1);
      if (gnt_seen) n_gnt_dut++;

      hit   = e_gnt && (bus.wr_addr[8:4] == 5'(m_line) ||
                        (bus.wr_addr[8:4] == 5'((m_line + 1) % 32) && pf_out > 0));
      rdy_n = m_rdy || (e_rdv && e_idx == 4'd15);
      if (e_rdv && pf_out > 0) pf_out--;

      if (rd_now >= 0) begin
         e_cen = 0; e_wen = 1; e_addr = 9'(rd_now);
      end else if (e_gnt) begin
         e_cen = 0; e_wen = 0; e_addr = bus.wr_addr; e_wdata = bus.wr_data;
         ref_mem[bus.wr_addr] = bus.wr_data;
         n_gnt_ref++;
         $display("write: addr=%03h data=%04h line=%0d slot=%0d cycle=%0d",
                  bus.wr_addr, bus.wr_data, m_line, m_slot, cyc);
      end else begin
         e_cen = 1; e_wen = 1;
      end

      e_rdv = p_v[1];
      if (p_v[1]) begin e_idx = p_idx[1]; e_dat = p_dat[1]; end
      p_v[1] = p_v[0]; p_idx[1] = p_idx[0]; p_dat[1] = p_dat[0];
      p_v[0] = (rd_now >= 0);
      if (rd_now >= 0) begin p_idx[0] = 4'(rd_now % 16); p_dat[0] = ref_mem[rd_now]; end

      wrap = 0;
      if (Vsync && m_rdy) begin
         if (m_pwm == 31) begin
            m_pwm = 0;
            if (m_slot == last) begin
               m_slot = 0; m_line = (m_line + 1) % 32; wrap = 1; m_mode = mode;
            end else m_slot++;
         end else m_pwm++;
      end
      m_start = wrap;
      if (!m_rdy && rdy_n) m_mode = mode;
      m_tear = hit || (m_tear && !(wrap && m_line == 0));
      m_rdy  = rdy_n;
      if (wrap) $display("line_start: line=%0d cycle=%0d", m_line, cyc);
      cyc++;
   endtask

   task automatic cycle();
      @(negedge GCK);
      compare();
      step();
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
      bus.wr_req  = 1'b0;
      bus.wr_addr = 9'd0;
      bus.wr_data = 16'd0;
      model_reset();
      repeat (2) @(negedge GCK);
      sram_load = 1'b0;
      check_reset();
      rst = 1'b0;
      step();

      // Abort priming part way: in-flight reads must not surface
      repeat (8) cycle();
      @(negedge GCK);
      rst = 1'b1;
      bus.wr_req = 1'b0;
      #1;
      check_reset();
      model_reset();
      repeat (2) @(negedge GCK);
      check_reset();
      rst = 1'b0;
      step();

      while (!(m_line == 1 && m_slot >= 1030) && cyc < 80000 && bad <= 50) cycle();

      chk("reached_line1_slot1030", (m_line == 1 && m_slot >= 1030), 1);
      chk("line_start_count", n_ls, 1);
      chk("write_grants", n_gnt_dut, n_gnt_ref);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
